shared_port_arbiter: RTL
========================

# shared_port_arbiter

Round-robin arbiter and sequencer that shares one single-owner resource port (e.g. a shared write port) between `N_REQ` requesters. It grants exactly one requester at a time and holds the grant until the resource signals completion or the owner withdraws. An optional watchdog forces release after a bounded hold time. It sits between the requester front-ends and the resource mux: the mux select is `grant_id`, and the resource reports completion via `res_done`.

## Interface
- `N_REQ`, 4: number of requesters; legal range 2..16.
- `MAX_HOLD`, 8: maximum cycles in BUSY before forced release; legal range ≥2. Used only with `ARB_TIMEOUT_EN`.
- `clk` input, 1: sole clock; all state updates on its rising edge.
- `rst` input, 1: reset, synchronous, active-high.
- `req` input, `N_REQ`: level request per requester; held until granted and served.
- `res_done` input, 1: resource finished current owner's transaction; single-cycle pulse.
- `grant` output, `N_REQ`: one-hot grant, or all-zero; registered.
- `grant_id` output, `$clog2(N_REQ)`: binary index of the owner; valid while `busy`; registered.
- `busy` output, 1: resource currently owned (state BUSY).
- `timeout` output, 1: one-cycle pulse on forced release.

## Operation
- States: IDLE, BUSY, RELEASE. Any unused state encoding returns to IDLE next cycle, with all outputs at reset values.
- Round-robin pointer `ptr` (`$clog2(N_REQ)` bits): the search starts at `ptr` and wraps from `N_REQ-1` to 0. The first set `req` bit wins.
- IDLE:
  - If `req != 0`, go to BUSY. Register `grant` (one-hot of the winner), `grant_id`, and `busy=1`. Clear the hold counter.
  - If `req == 0`, stay in IDLE.
- BUSY: leave for RELEASE on the first of the following, in priority order:
  - `res_done`;
  - `req[grant_id]` deasserted;
  - hold counter == `MAX_HOLD-1` (timeout build only).
- On leaving BUSY:
  - `ptr` ← `grant_id+1`, modulo `N_REQ` (wraps `N_REQ-1` → 0).
  - `grant`, `busy` ← 0.
  - `timeout` ← 1 only if the exit cause is the hold limit.
- RELEASE: one dead cycle, so the resource mux sees no owner. Go to IDLE unconditionally and clear `timeout`.
- `res_done` outside BUSY is ignored.
- `req` changes on non-owner bits during BUSY are ignored. They are arbitrated at the next IDLE.
- Hold counter:
  - Width is `$clog2(MAX_HOLD)`.
  - It increments each BUSY cycle, saturates at `MAX_HOLD-1`, and never wraps.
- Reset values: state IDLE, `ptr`=0, hold counter 0, `grant`=0, `grant_id`=0, `busy`=0, `timeout`=0.

## Timing
- Request-to-grant latency: `req` sampled high in IDLE at edge t → `grant`/`busy` high after edge t.
- Minimum back-to-back spacing: BUSY exit edge → RELEASE → IDLE → BUSY. An owner handover therefore takes 2 cycles with `grant==0`.
- `res_done` in the first BUSY cycle is legal and gives a 1-cycle ownership.
- Simultaneous `res_done` and hold-limit: `res_done` wins, and `timeout` stays 0.
- Timeout position: entering BUSY at edge e with no `res_done` → exit at edge `e+MAX_HOLD`. `timeout` is high for the following cycle.
- `rst` high at any edge, including mid-BUSY: all registers take reset values at that edge, and `grant` drops in the same cycle as the reset edge. No `timeout` pulse is generated by reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - hold counter, watchdog exit and `timeout` pulse are present as above.
- `ARB_TIMEOUT_EN` undefined:
  - no hold counter is built;
  - `timeout` is tied 0;
  - BUSY exits only on `res_done` or owner `req` deassertion;
  - `MAX_HOLD` is ignored.

## Structure
- Package `shared_port_arbiter_pkg` holds:
  - `arb_state_t` enum (IDLE, BUSY, RELEASE), with explicit 2-bit encoding;
  - the exit-cause enum `arb_exit_t` (NONE, DONE, DROP, TIMEOUT).
- Sub-module `rr_pick` (combinational):
  - inputs `req`, `ptr`;
  - outputs `found`, `idx`.
  - It performs the rotate / priority-encode / unrotate.
- The top holds the FSM, the pointer and the hold counter.

## Test plan
- Reset, then `req=4'b0000` for 10 cycles → `grant=0`, `busy=0`, `timeout=0` throughout.
- Pointer advance:
  - `req=4'b1010` held and `ptr=0` → `grant=4'b0010`, `grant_id=1` one cycle later;
  - `res_done` pulse → after RELEASE and IDLE, `grant=4'b1000`.
- Wrap-around:
  - owner 3 served, then `req=4'b1001` → next grant `4'b0001` (`ptr` wrapped to 0).
- Watchdog (`ARB_TIMEOUT_EN`, `MAX_HOLD=8`):
  - `req=4'b0100`, no `res_done` → grant exactly 8 cycles;
  - `timeout` single pulse in the RELEASE cycle;
  - same stimulus without the macro → grant held indefinitely.
- Simultaneous events: `res_done` on the hold-limit cycle → release, `timeout=0`.
- Owner drop and reset:
  - owner drops `req` mid-BUSY → release next edge, `timeout=0`;
  - `rst` asserted mid-BUSY → `grant=0` and `ptr=0` after that edge.

Source files
------------

// File: rtl/shared_port_arbiter_pkg.sv
// shared_port_arbiter_pkg
//   Shared types for the shared-port arbiter: the FSM state encoding and the
//   classification of why an owner left BUSY.
package shared_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUSY    = 2'b01,
    RELEASE = 2'b10
  } arb_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'b00,
    DONE    = 2'b01,
    DROP    = 2'b10,
    TIMEOUT = 2'b11
  } arb_exit_t;

endpackage

// File: rtl/shared_port_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin search: returns the first set request at or
//   after ptr, wrapping from N_REQ-1 to 0.
//   Ports:
//     req   [N_REQ-1:0]  request vector
//     ptr   [IDX_W-1:0]  search start position
//     found              at least one request is set
//     idx   [IDX_W-1:0]  index of the winning requester (0 when !found)
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  always_comb begin
    // Rotate right by ptr so the search start lands on bit 0.
    req_dbl = {req, req};
    req_rot = req_dbl[ptr +: N_REQ];
    found   = |req_rot;

    // Lowest set bit of the rotated vector; scanning downward lets the
    // smallest index overwrite larger ones.
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) off = IDX_W'(i);
    end

    // Unrotate: (ptr + off) mod N_REQ, with one extra bit for the carry.
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/shared_port_arbiter.sv
// shared_port_arbiter
//   Round-robin arbiter sharing one single-owner resource port among N_REQ
//   requesters. One owner at a time; the grant is held until the resource
//   reports res_done or the owner drops its request, followed by one dead
//   RELEASE cycle before the next arbitration.
//   Optional watchdog: define ARB_TIMEOUT_EN to force release after MAX_HOLD
//   cycles in BUSY and pulse timeout. Without it, timeout is tied 0.
//   Ports:
//     clk                   clock, rising edge
//     rst                   synchronous active-high reset
//     req      [N_REQ-1:0]  level requests
//     res_done              resource finished the current owner (pulse)
//     grant    [N_REQ-1:0]  one-hot grant or zero, registered
//     grant_id [IDX_W-1:0]  owner index, valid while busy, registered
//     busy                  resource owned (BUSY state), registered
//     timeout               one-cycle pulse on forced release, registered
module shared_port_arbiter
  import shared_port_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     res_done,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("shared_port_arbiter: N_REQ must be in 2..16");
  end
  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("shared_port_arbiter: MAX_HOLD must be >= 2");
  end

  arb_state_t       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] grant_id_q;
  logic             busy_q;
  arb_exit_t        exit_d;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q;
  logic              timeout_q;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Exit cause while BUSY; res_done outranks a drop, which outranks the watchdog.
  always_comb begin
    exit_d = NONE;
    if (res_done) begin
      exit_d = DONE;
    end else if (!req[grant_id_q]) begin
      exit_d = DROP;
    end
`ifdef ARB_TIMEOUT_EN
    else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
      exit_d = TIMEOUT;
    end
`endif
  end

  // Pointer moves one past the departing owner, wrapping at N_REQ-1.
  always_comb begin
    if (grant_id_q == IDX_W'(N_REQ - 1)) ptr_d = '0;
    else                                 ptr_d = grant_id_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      grant_q    <= '0;
      grant_id_q <= '0;
      busy_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q    <= BUSY;
            grant_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
            grant_id_q <= pick_idx;
            busy_q     <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            hold_q     <= '0;
`endif
          end
        end
        BUSY: begin
          if (exit_d != NONE) begin
            state_q   <= RELEASE;
            ptr_q     <= ptr_d;
            grant_q   <= '0;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            timeout_q <= (exit_d == TIMEOUT);
`endif
          end
`ifdef ARB_TIMEOUT_EN
          // Saturating; cleared again on the next entry into BUSY.
          if (hold_q != HOLD_W'(MAX_HOLD - 1)) hold_q <= hold_q + 1'b1;
`endif
        end
        RELEASE: begin
          state_q   <= IDLE;
`ifdef ARB_TIMEOUT_EN
          timeout_q <= 1'b0;
`endif
        end
        default: begin
          state_q    <= IDLE;
          ptr_q      <= '0;
          grant_q    <= '0;
          grant_id_q <= '0;
          busy_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          hold_q     <= '0;
          timeout_q  <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign grant    = grant_q;
  assign grant_id = grant_id_q;
  assign busy     = busy_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout  = timeout_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule
